// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned REG_IDX_W    = $clog2(NUM_REGS_DEF);

    // Operand forward select; the spare encoding 3 behaves as FWD_RF in the mux
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/execute/memory hazard inputs and stall/flush/forward outputs.
// Counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic [IDX_W-1:0] rs1_d;
    logic [IDX_W-1:0] rs2_d;
    logic             use_rs1_d;
    logic             use_rs2_d;
    logic [IDX_W-1:0] rd_e;
    logic [IDX_W-1:0] rd_m;
    logic             rf_en_e;
    logic             rf_en_m;
    logic             mem_read_e;
    logic             redirect;
    logic             ext_stall;
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic             flush_e;
    logic             flush_m;
    logic [1:0]       fwd_a_e;
    logic [1:0]       fwd_b_e;
`ifdef HAZARD_PERF_EN
    logic [XLEN-1:0]  perf_stall_cnt;
    logic [XLEN-1:0]  perf_flush_cnt;
`endif

    // Pipeline side
    modport master (
        output rs1_d, rs2_d, use_rs1_d, use_rs2_d, rd_e, rd_m,
        output rf_en_e, rf_en_m, mem_read_e, redirect, ext_stall,
`ifdef HAZARD_PERF_EN
        input  perf_stall_cnt, perf_flush_cnt,
`endif
        input  stall_f, stall_d, flush_d, flush_e, flush_m, fwd_a_e, fwd_b_e
    );

    // Hazard controller side
    modport slave (
        input  rs1_d, rs2_d, use_rs1_d, use_rs2_d, rd_e, rd_m,
        input  rf_en_e, rf_en_m, mem_read_e, redirect, ext_stall,
`ifdef HAZARD_PERF_EN
        output perf_stall_cnt, perf_flush_cnt,
`endif
        output stall_f, stall_d, flush_d, flush_e, flush_m, fwd_a_e, fwd_b_e
    );

endinterface

// File: rtl/hazard_fwd_cmp.sv
// Per-operand RAW comparator: forward select plus load-use flag for one source register.
module hazard_fwd_cmp
    import hazard_pkg::*;
#(
    parameter int unsigned IDX_W = REG_IDX_W
) (
    input  logic [IDX_W-1:0] rs_i,
    input  logic             use_rs_i,
    input  logic [IDX_W-1:0] rd_e_i,
    input  logic             rf_en_e_i,
    input  logic [IDX_W-1:0] rd_m_i,
    input  logic             rf_en_m_i,
    input  logic             mem_read_e_i,
    output fwd_sel_t         sel_o,
    output logic             load_use_o
);

    logic hit_e;
    logic hit_m;

    // The Execute-stage producer is younger, so its match wins
    always_comb begin
        hit_e      = use_rs_i && rf_en_e_i && (rd_e_i != '0) && (rs_i == rd_e_i);
        hit_m      = rf_en_m_i && (rd_m_i != '0) && (rs_i == rd_m_i);
        sel_o      = FWD_RF;
        if (hit_e) begin
            sel_o = FWD_MEM;
        end else if (hit_m) begin
            sel_o = FWD_WB;
        end
        load_use_o = mem_read_e_i && hit_e;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, redirect flush, registered D/E forward selects.
// Optional HAZARD_PERF_EN adds stall/flush event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    hazard_state_t state_q, state_d;
    fwd_sel_t      fwd_a_q, fwd_a_d;
    fwd_sel_t      fwd_b_q, fwd_b_d;
    fwd_sel_t      sel_a, sel_b;
    logic          lu_a, lu_b, load_use;
    logic          stall_f_c, stall_d_c, flush_d_c, flush_e_c, flush_m_c;
`ifdef HAZARD_PERF_EN
    logic            stall_ev, flush_ev;
    logic [XLEN-1:0] stall_cnt_q, flush_cnt_q;
`endif

    hazard_fwd_cmp #(.IDX_W(IDX_W)) u_cmp_a (
        .rs_i(hz.rs1_d), .use_rs_i(hz.use_rs1_d),
        .rd_e_i(hz.rd_e), .rf_en_e_i(hz.rf_en_e),
        .rd_m_i(hz.rd_m), .rf_en_m_i(hz.rf_en_m),
        .mem_read_e_i(hz.mem_read_e), .sel_o(sel_a), .load_use_o(lu_a)
    );

    hazard_fwd_cmp #(.IDX_W(IDX_W)) u_cmp_b (
        .rs_i(hz.rs2_d), .use_rs_i(hz.use_rs2_d),
        .rd_e_i(hz.rd_e), .rf_en_e_i(hz.rf_en_e),
        .rd_m_i(hz.rd_m), .rf_en_m_i(hz.rf_en_m),
        .mem_read_e_i(hz.mem_read_e), .sel_o(sel_b), .load_use_o(lu_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            state_q <= state_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // Priority: ext_stall freezes everything, redirect beats load-use.
    // The STALL state masks load-use so one load never stalls twice.
    always_comb begin
        state_d   = state_q;
        fwd_a_d   = fwd_a_q;
        fwd_b_d   = fwd_b_q;
        stall_f_c = 1'b0;
        stall_d_c = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        flush_m_c = 1'b0;
`ifdef HAZARD_PERF_EN
        stall_ev  = 1'b0;
        flush_ev  = 1'b0;
`endif
        load_use  = (lu_a || lu_b) && (state_q != STALL);
        if (!rst) begin
            if (hz.ext_stall) begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
            end else if (hz.redirect) begin
                flush_d_c = 1'b1;
                flush_e_c = 1'b1;
                flush_m_c = 1'b1;
                fwd_a_d   = FWD_RF;
                fwd_b_d   = FWD_RF;
                state_d   = FLUSH;
`ifdef HAZARD_PERF_EN
                flush_ev  = 1'b1;
`endif
            end else if (load_use) begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                flush_e_c = 1'b1;
                fwd_a_d   = FWD_RF;
                fwd_b_d   = FWD_RF;
                state_d   = STALL;
`ifdef HAZARD_PERF_EN
                stall_ev  = 1'b1;
`endif
            end else begin
                fwd_a_d   = sel_a;
                fwd_b_d   = sel_b;
                state_d   = RUN;
            end
        end
    end

    assign hz.stall_f = stall_f_c;
    assign hz.stall_d = stall_d_c;
    assign hz.flush_d = flush_d_c;
    assign hz.flush_e = flush_e_c;
    assign hz.flush_m = flush_m_c;
    assign hz.fwd_a_e = fwd_a_q;
    assign hz.fwd_b_e = fwd_b_q;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_ev) stall_cnt_q <= stall_cnt_q + XLEN'(1);
            if (flush_ev) flush_cnt_q <= flush_cnt_q + XLEN'(1);
        end
    end

    assign hz.perf_stall_cnt = stall_cnt_q;
    assign hz.perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (counter checks active with HAZARD_PERF_EN).
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.XLEN(32), .NUM_REGS(32)) hz ();

    hazard_ctrl #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        hz.rs1_d = '0; hz.rs2_d = '0; hz.use_rs1_d = 1'b0; hz.use_rs2_d = 1'b0;
        hz.rd_e = '0; hz.rd_m = '0; hz.rf_en_e = 1'b0; hz.rf_en_m = 1'b0;
        hz.mem_read_e = 1'b0; hz.redirect = 1'b0; hz.ext_stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        step();
        step();
        chk("rst_fwd_a", 32'(hz.fwd_a_e), 32'd0);
        chk("rst_fwd_b", 32'(hz.fwd_b_e), 32'd0);
        chk("rst_stall_f", 32'(hz.stall_f), 32'd0);
        chk("rst_flush_d", 32'(hz.flush_d), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(RUN));

        // Back-to-back ALU: producer x5 in E
        rst = 1'b0;
        hz.rd_e = 5'd5; hz.rf_en_e = 1'b1; hz.rs1_d = 5'd5; hz.use_rs1_d = 1'b1;
        #1;
        chk("b2b_no_stall", 32'(hz.stall_f), 32'd0);
        step();
        chk("b2b_fwd_a", 32'(hz.fwd_a_e), 32'd1);

        // Distance 2: producer x7 in M, then in both E and M
        clear_in();
        hz.rd_m = 5'd7; hz.rf_en_m = 1'b1; hz.rs2_d = 5'd7; hz.use_rs2_d = 1'b1;
        step();
        chk("d2_fwd_b", 32'(hz.fwd_b_e), 32'd2);
        chk("d2_fwd_a", 32'(hz.fwd_a_e), 32'd0);
        hz.rd_e = 5'd7; hz.rf_en_e = 1'b1;
        step();
        chk("em_fwd_b", 32'(hz.fwd_b_e), 32'd1);

        // Load-use: lw x3 in E, Decode reads x3
        clear_in();
        hz.rd_e = 5'd3; hz.rf_en_e = 1'b1; hz.mem_read_e = 1'b1;
        hz.rs1_d = 5'd3; hz.use_rs1_d = 1'b1;
        #1;
        chk("lu_stall_f", 32'(hz.stall_f), 32'd1);
        chk("lu_stall_d", 32'(hz.stall_d), 32'd1);
        chk("lu_flush_e", 32'(hz.flush_e), 32'd1);
        chk("lu_flush_d", 32'(hz.flush_d), 32'd0);
        step();
        chk("lu_fwd_a_bubble", 32'(hz.fwd_a_e), 32'd0);
        chk("lu_state_stall", 32'(dut.state_q), 32'(STALL));
        hz.rd_e = '0; hz.rf_en_e = 1'b0; hz.mem_read_e = 1'b0;
        hz.rd_m = 5'd3; hz.rf_en_m = 1'b1;
        #1;
        chk("lu_release_stall", 32'(hz.stall_f), 32'd0);
        chk("lu_release_flush", 32'(hz.flush_e), 32'd0);
        step();
        chk("lu_fwd_a_wb", 32'(hz.fwd_a_e), 32'd2);
        chk("lu_state_run", 32'(dut.state_q), 32'(RUN));

        // x0 destination and unused operand
        clear_in();
        hz.rd_e = 5'd0; hz.rf_en_e = 1'b1; hz.mem_read_e = 1'b1;
        hz.rs1_d = 5'd0; hz.use_rs1_d = 1'b1;
        #1;
        chk("x0_no_stall", 32'(hz.stall_f), 32'd0);
        step();
        chk("x0_fwd_a", 32'(hz.fwd_a_e), 32'd0);
        clear_in();
        hz.rd_e = 5'd9; hz.rf_en_e = 1'b1; hz.mem_read_e = 1'b1;
        hz.rs2_d = 5'd9; hz.use_rs2_d = 1'b0;
        #1;
        chk("unused_no_stall", 32'(hz.stall_f), 32'd0);
        step();
        chk("unused_fwd_b", 32'(hz.fwd_b_e), 32'd0);

        // Redirect coincident with load-use, from a fresh reset
        clear_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        hz.rd_e = 5'd5; hz.rf_en_e = 1'b1; hz.rs1_d = 5'd5; hz.use_rs1_d = 1'b1;
        step();
        chk("pre_redir_fwd_a", 32'(hz.fwd_a_e), 32'd1);
        hz.rd_e = 5'd3; hz.mem_read_e = 1'b1; hz.rs1_d = 5'd3; hz.redirect = 1'b1;
        #1;
        chk("redir_flush_d", 32'(hz.flush_d), 32'd1);
        chk("redir_flush_e", 32'(hz.flush_e), 32'd1);
        chk("redir_flush_m", 32'(hz.flush_m), 32'd1);
        chk("redir_stall_f", 32'(hz.stall_f), 32'd0);
        chk("redir_stall_d", 32'(hz.stall_d), 32'd0);
        step();
        chk("redir_state", 32'(dut.state_q), 32'(FLUSH));
        chk("redir_fwd_a", 32'(hz.fwd_a_e), 32'd0);
        clear_in();
        #1;
        chk("post_redir_flush", 32'(hz.flush_d), 32'd0);
        step();
        chk("post_redir_state", 32'(dut.state_q), 32'(RUN));
`ifdef HAZARD_PERF_EN
        chk("perf_flush_1", hz.perf_flush_cnt, 32'd1);
        chk("perf_stall_0", hz.perf_stall_cnt, 32'd0);
`endif

        // ext_stall held 3 cycles over a pending redirect
        hz.rd_e = 5'd5; hz.rf_en_e = 1'b1; hz.rs1_d = 5'd5; hz.use_rs1_d = 1'b1;
        step();
        chk("pre_ext_fwd_a", 32'(hz.fwd_a_e), 32'd1);
        hz.rd_e = '0; hz.rf_en_e = 1'b0; hz.rd_m = 5'd5; hz.rf_en_m = 1'b1;
        hz.redirect = 1'b1; hz.ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ext_stall_f", 32'(hz.stall_f), 32'd1);
            chk("ext_flush_d", 32'(hz.flush_d), 32'd0);
            chk("ext_flush_e", 32'(hz.flush_e), 32'd0);
            step();
            chk("ext_fwd_hold", 32'(hz.fwd_a_e), 32'd1);
        end
        hz.ext_stall = 1'b0;
        #1;
        chk("ext_rel_flush_m", 32'(hz.flush_m), 32'd1);
        chk("ext_rel_stall_f", 32'(hz.stall_f), 32'd0);
        step();
        chk("ext_rel_state", 32'(dut.state_q), 32'(FLUSH));
        chk("ext_rel_fwd_a", 32'(hz.fwd_a_e), 32'd0);
`ifdef HAZARD_PERF_EN
        chk("perf_flush_2", hz.perf_flush_cnt, 32'd2);
`endif
        clear_in();
        step();

        // Reset asserted mid-STALL
        hz.rd_e = 5'd4; hz.rf_en_e = 1'b1; hz.mem_read_e = 1'b1;
        hz.rs2_d = 5'd4; hz.use_rs2_d = 1'b1;
        step();
        chk("mid_state_stall", 32'(dut.state_q), 32'(STALL));
        rst = 1'b1;
        step();
        chk("rst_mid_state", 32'(dut.state_q), 32'(RUN));
        chk("rst_mid_fwd_b", 32'(hz.fwd_b_e), 32'd0);
        chk("rst_mid_stall_f", 32'(hz.stall_f), 32'd0);
        chk("rst_mid_flush_e", 32'(hz.flush_e), 32'd0);
`ifdef HAZARD_PERF_EN
        chk("rst_mid_perf_stall", hz.perf_stall_cnt, 32'd0);
        chk("rst_mid_perf_flush", hz.perf_flush_cnt, 32'd0);
`endif
        rst = 1'b0;
        clear_in();
        #1;
        chk("post_rst_stall_d", 32'(hz.stall_d), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
